// File: rtl/trivium_pkg.sv
// Shared constants, FSM encoding and load-state helper for the Trivium
// keystream generator.
//   INIT_ROUNDS : warm-up update steps before keystream is emitted
//   STATE_W     : cipher state width (s1..s288 map to bits [0]..[287])
//   KEY_W, IV_W : key and IV widths
package trivium_pkg;

    localparam int INIT_ROUNDS = 1152;
    localparam int STATE_W     = 288;
    localparam int KEY_W       = 80;
    localparam int IV_W        = 80;
    localparam int CNT_W       = 11;

    localparam logic [KEY_W-1:0] DEFAULT_KEY = '0;
    localparam logic [IV_W-1:0]  DEFAULT_IV  = '0;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_INIT = 2'd1,
        ST_GEN  = 2'd2
    } fsm_t;

    // Builds the initial state. Bit index i holds s(i+1), so the key MSB
    // lands in bit 0 (s1) and the IV MSB lands in bit 93 (s94).
    function automatic logic [STATE_W-1:0] load_state(
        input logic [KEY_W-1:0] key,
        input logic [IV_W-1:0]  iv
    );
        logic [STATE_W-1:0] s;
        s = '0;
        for (int i = 0; i < KEY_W; i++) s[i]      = key[KEY_W-1-i];
        for (int i = 0; i < IV_W;  i++) s[93 + i] = iv[IV_W-1-i];
        s[STATE_W-1 -: 3] = 3'b111;
        return s;
    endfunction

endpackage

// File: rtl/trivium_core.sv
// One combinational Trivium update step.
//   state_in  : current state, bit i = s(i+1)
//   state_out : state after one update step
//   z         : keystream bit produced by this step
module trivium_core
    import trivium_pkg::*;
(
    input  logic [STATE_W-1:0] state_in,
    output logic [STATE_W-1:0] state_out,
    output logic               z
);

    logic l1, l2, l3;
    logic t1, t2, t3;

    always_comb begin
        // Linear taps form the output bit before the nonlinear feedback.
        l1 = state_in[65]  ^ state_in[92];
        l2 = state_in[161] ^ state_in[176];
        l3 = state_in[242] ^ state_in[287];
        z  = l1 ^ l2 ^ l3;

        t1 = l1 ^ (state_in[90]  & state_in[91])  ^ state_in[170];
        t2 = l2 ^ (state_in[174] & state_in[175]) ^ state_in[263];
        t3 = l3 ^ (state_in[285] & state_in[286]) ^ state_in[68];

        // Three shift registers: s1..s93, s94..s177, s178..s288, each fed
        // at its low end by the feedback of the preceding register.
        state_out = {state_in[286:177], t2,
                     state_in[175:93],  t1,
                     state_in[91:0],    t3};
    end

endmodule

// File: rtl/trivium.sv
// Trivium keystream generator with a one-byte output handshake.
//   clk             : clock, all registers update on the rising edge
//   rst_n           : synchronous reset, active HIGH despite the name
//   keystream_read  : consumer pops the presented byte (ignored when not valid)
//   keystream_byte  : presented keystream byte, first generated bit in bit 7
//   keystream_valid : keystream_byte holds an unconsumed byte
// Parameters KEY and IV are fixed at elaboration; there are no key/IV ports.
module trivium
    import trivium_pkg::*;
#(
    parameter logic [KEY_W-1:0] KEY = DEFAULT_KEY,
    parameter logic [IV_W-1:0]  IV  = DEFAULT_IV
)(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       keystream_read,
    output logic [7:0] keystream_byte,
    output logic       keystream_valid
);

    localparam logic [STATE_W-1:0] LOAD_VALUE = load_state(KEY, IV);
    localparam logic [CNT_W-1:0]   LAST_INIT  = CNT_W'(INIT_ROUNDS - 1);

    fsm_t               fsm_q,   fsm_d;
    logic [STATE_W-1:0] state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [6:0]         col_q,   col_d;
    logic [2:0]         nbits_q, nbits_d;
    logic [7:0]         byte_q,  byte_d;
    logic               valid_q, valid_d;

    logic [STATE_W-1:0] core_next;
    logic               core_z;

    trivium_core u_core (
        .state_in  (state_q),
        .state_out (core_next),
        .z         (core_z)
    );

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        col_d   = col_q;
        nbits_d = nbits_q;
        byte_d  = byte_q;
        valid_d = valid_q;

        if (keystream_read && valid_q) valid_d = 1'b0;

        unique case (fsm_q)
            ST_LOAD: begin
                state_d = LOAD_VALUE;
                cnt_d   = '0;
                fsm_d   = ST_INIT;
            end
            ST_INIT: begin
                state_d = core_next;
                if (cnt_q == LAST_INIT) begin
                    cnt_d = '0;
                    fsm_d = ST_GEN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_GEN: begin
                if (nbits_q != 3'd7) begin
                    state_d = core_next;
                    col_d   = {col_q[5:0], core_z};
                    nbits_d = nbits_q + 1'b1;
                end else if (!valid_q || keystream_read) begin
                    // The 8th bit goes straight into the output register,
                    // so a byte is handed over on the same step it completes.
                    state_d = core_next;
                    byte_d  = {col_q, core_z};
                    valid_d = 1'b1;
                    col_d   = '0;
                    nbits_d = '0;
                end
                // Otherwise stall: output is full and not being read.
            end
            default: fsm_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            fsm_q   <= ST_LOAD;
            cnt_q   <= '0;
            col_q   <= '0;
            nbits_q <= '0;
            byte_q  <= 8'h00;
            valid_q <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            cnt_q   <= cnt_d;
            col_q   <= col_d;
            nbits_q <= nbits_d;
            byte_q  <= byte_d;
            valid_q <= valid_d;
        end
    end

    // The cipher state is overwritten in LOAD, so it needs no reset.
    always_ff @(posedge clk) begin
        state_q <= state_d;
    end

    assign keystream_byte  = byte_q;
    assign keystream_valid = valid_q;

endmodule

// File: tb/tb_trivium.sv
module tb_trivium;

    localparam int NREF = 100;
    localparam int FIRST_K = 1161;
    localparam logic [79:0] TB_KEY = '0;
    localparam logic [79:0] TB_IV  = '0;

    logic       clk;
    logic       rst_n;
    logic       keystream_read;
    logic [7:0] keystream_byte;
    logic       keystream_valid;

    int checks = 0;
    int errors = 0;

    logic [7:0] ref_bytes [0:NREF-1];
    bit         rs [1:288];

    trivium #(.KEY(TB_KEY), .IV(TB_IV)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .keystream_read  (keystream_read),
        .keystream_byte  (keystream_byte),
        .keystream_valid (keystream_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference keystream straight from the cipher definition, using the
    // 1-based s1..s288 numbering and a plain bit list.
    task automatic build_ref();
        bit t1, t2, t3, z;
        bit bits [$];
        for (int i = 1; i <= 288; i++) rs[i] = 1'b0;
        for (int i = 1; i <= 80; i++) rs[i] = TB_KEY[80 - i];
        for (int i = 1; i <= 80; i++) rs[93 + i] = TB_IV[80 - i];
        rs[286] = 1'b1; rs[287] = 1'b1; rs[288] = 1'b1;
        for (int step = 0; step < 1152 + 8 * NREF; step++) begin
            t1 = rs[66] ^ rs[93];
            t2 = rs[162] ^ rs[177];
            t3 = rs[243] ^ rs[288];
            z  = t1 ^ t2 ^ t3;
            t1 = t1 ^ (rs[91] & rs[92]) ^ rs[171];
            t2 = t2 ^ (rs[175] & rs[176]) ^ rs[264];
            t3 = t3 ^ (rs[286] & rs[287]) ^ rs[69];
            for (int i = 93; i >= 2; i--) rs[i] = rs[i - 1];
            rs[1] = t3;
            for (int i = 177; i >= 95; i--) rs[i] = rs[i - 1];
            rs[94] = t1;
            for (int i = 288; i >= 179; i--) rs[i] = rs[i - 1];
            rs[178] = t2;
            if (step >= 1152) bits.push_back(z);
        end
        for (int n = 0; n < NREF; n++) begin
            logic [7:0] b;
            b = 8'h00;
            for (int j = 0; j < 8; j++) b = {b[6:0], bits[8 * n + j]};
            ref_bytes[n] = b;
        end
    endtask

    // Releases reset and counts edges until the first valid byte appears.
    task automatic release_and_wait(output int k);
        @(negedge clk);
        rst_n = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!keystream_valid && k < 1400);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        keystream_read = 1'b0;
        apply_reset();
        checks++;
        if (keystream_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid got %0b want 0", keystream_valid);
        end
        checks++;
        if (keystream_byte !== 8'h00) begin
            errors++;
            $display("FAIL reset_byte got %02h want 00", keystream_byte);
        end
    endtask

    // No reads: first valid timing, then a held byte, then drain after a stall.
    task automatic test_stall();
        int k, n, cyc;
        logic [7:0] held;
        bit unstable;
        keystream_read = 1'b0;
        apply_reset();
        release_and_wait(k);
        checks++;
        if (k !== FIRST_K) begin
            errors++;
            $display("FAIL stall_first_valid cycle %0d want %0d", k, FIRST_K);
        end
        checks++;
        if (keystream_byte !== ref_bytes[0]) begin
            errors++;
            $display("FAIL stall_first_byte got %02h want %02h", keystream_byte, ref_bytes[0]);
        end
        held = keystream_byte;
        unstable = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (keystream_valid !== 1'b1 || keystream_byte !== held) unstable = 1'b1;
        end
        checks++;
        if (unstable) begin
            errors++;
            $display("FAIL stall_hold byte %02h valid %0b want %02h valid 1",
                     keystream_byte, keystream_valid, held);
        end
        n = 0;
        cyc = 0;
        while (n < 64 && cyc < 2000) begin
            keystream_read = 1'b1;
            if (keystream_valid) begin
                checks++;
                if (keystream_byte !== ref_bytes[n]) begin
                    errors++;
                    $display("FAIL stall_byte[%0d] got %02h want %02h", n, keystream_byte, ref_bytes[n]);
                end
                n++;
            end
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (n != 64) begin
            errors++;
            $display("FAIL stall_drain_timeout got %0d bytes want 64", n);
        end
        keystream_read = 1'b0;
    endtask

    // Read held high from before reset release: bytes every 8 cycles.
    task automatic test_stream();
        int k, n, cyc;
        keystream_read = 1'b1;
        apply_reset();
        release_and_wait(k);
        checks++;
        if (k !== FIRST_K) begin
            errors++;
            $display("FAIL stream_first_valid cycle %0d want %0d", k, FIRST_K);
        end
        n = 0;
        cyc = k;
        while (n < 64 && cyc < FIRST_K + 1000) begin
            if (keystream_valid) begin
                checks++;
                if (keystream_byte !== ref_bytes[n]) begin
                    errors++;
                    $display("FAIL stream_byte[%0d] got %02h want %02h", n, keystream_byte, ref_bytes[n]);
                end
                checks++;
                if (cyc != FIRST_K + 8 * n) begin
                    errors++;
                    $display("FAIL stream_time[%0d] cycle %0d want %0d", n, cyc, FIRST_K + 8 * n);
                end
                n++;
            end
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (n != 64) begin
            errors++;
            $display("FAIL stream_timeout got %0d bytes want 64", n);
        end
        keystream_read = 1'b0;
    endtask

    // Random consumer: every popped byte in order, held bytes stay stable.
    task automatic test_random_read();
        int k, n, cyc;
        bit prev_valid, prev_pop, bad_hold;
        logic [7:0] prev_byte;
        keystream_read = 1'b0;
        apply_reset();
        keystream_read = 1'($urandom_range(0, 1));
        release_and_wait(k);
        n = 0;
        cyc = 0;
        prev_valid = 1'b0;
        prev_pop = 1'b0;
        prev_byte = 8'h00;
        bad_hold = 1'b0;
        while (n < 80 && cyc < 8000) begin
            keystream_read = ($urandom_range(0, 3) != 0);
            if (prev_valid && !prev_pop && keystream_valid && keystream_byte !== prev_byte)
                bad_hold = 1'b1;
            if (prev_valid && !prev_pop && !keystream_valid)
                bad_hold = 1'b1;
            prev_valid = keystream_valid;
            prev_byte = keystream_byte;
            prev_pop = keystream_valid && keystream_read;
            if (keystream_valid && keystream_read) begin
                checks++;
                if (keystream_byte !== ref_bytes[n]) begin
                    errors++;
                    $display("FAIL random_byte[%0d] got %02h want %02h", n, keystream_byte, ref_bytes[n]);
                end
                n++;
            end
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (n != 80) begin
            errors++;
            $display("FAIL random_timeout got %0d bytes want 80", n);
        end
        checks++;
        if (bad_hold) begin
            errors++;
            $display("FAIL random_hold unconsumed byte changed or vanished, want stable");
        end
        keystream_read = 1'b0;
    endtask

    // Reset during INIT and during GEN restarts the full warm-up.
    task automatic test_reset_abort();
        int k, n, cyc;
        keystream_read = 1'b0;
        apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (500) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        release_and_wait(k);
        checks++;
        if (k !== FIRST_K) begin
            errors++;
            $display("FAIL init_abort_first cycle %0d want %0d", k, FIRST_K);
        end
        n = 0;
        cyc = 0;
        keystream_read = 1'b1;
        while (n < 5 && cyc < 200) begin
            if (keystream_valid) n++;
            @(negedge clk);
            cyc++;
        end
        keystream_read = 1'b0;
        cyc = 0;
        while (!keystream_valid && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (keystream_valid !== 1'b1 || n != 5) begin
            errors++;
            $display("FAIL gen_abort_setup valid %0b bytes %0d want valid 1 bytes 5", keystream_valid, n);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (keystream_valid !== 1'b0 || keystream_byte !== 8'h00) begin
            errors++;
            $display("FAIL gen_abort_clear valid %0b byte %02h want 0 00", keystream_valid, keystream_byte);
        end
        @(negedge clk);
        release_and_wait(k);
        checks++;
        if (k !== FIRST_K) begin
            errors++;
            $display("FAIL gen_abort_first cycle %0d want %0d", k, FIRST_K);
        end
        checks++;
        if (keystream_byte !== ref_bytes[0]) begin
            errors++;
            $display("FAIL gen_abort_byte got %02h want %02h", keystream_byte, ref_bytes[0]);
        end
    endtask

    initial begin
        rst_n = 1'b1;
        keystream_read = 1'b0;
        build_ref();
        test_reset();
        test_stall();
        test_stream();
        test_random_read();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/trivium.md
TRIVIUM -- requirements
Module: trivium

Interface
REQ-001 The block SHALL have ports `clk`, input, 1 bit: the single clock; every register updates on its rising edge.
REQ-002 The block SHALL have port `rst_n`, input, 1 bit: reset, synchronous and active-high despite the name.
REQ-003 The block SHALL have port `keystream_read`, input, 1 bit: consumer pops the presented byte.
REQ-004 The block SHALL have port `keystream_byte`, output, 8 bits: presented keystream byte.
REQ-005 The block SHALL have port `keystream_valid`, output, 1 bit: `keystream_byte` holds an unconsumed byte.
REQ-006 The block SHALL have parameters KEY, 80 bits, default all zeros: cipher key. It SHALL have IV, 80 bits, default all zeros: initialisation vector. There SHALL be no key or IV ports.

Function
REQ-007 State: 288-bit register s1..s288.
- Load: s1..s80 = KEY[79:0], with KEY[79] into s1; s81..s93 = 0.
- s94..s173 = IV[79:0], with IV[79] into s94; s174..s285 = 0; s286..s288 = 1.
REQ-008 Each update step SHALL compute:
- t1=s66^s93, t2=s162^s177, t3=s243^s288, z=t1^t2^t3.
- Then t1^=(s91&s92)^s171, t2^=(s175&s176)^s264, t3^=(s286&s287)^s69.
- Shift: s1..s93 <= t3,s1..s92; s94..s177 <= t1,s94..s176; s178..s288 <= t2,s178..s287.
REQ-009 FSM states:
- LOAD: one cycle, applies the REQ-007 load.
- INIT: exactly 1152 update steps, one per cycle, with z discarded; an 11-bit counter 0..1151 moves the FSM to GEN after count 1151.
- GEN: one update step per cycle unless stalled.
REQ-010 In GEN, each z SHALL shift into an 8-bit collector from the LSB side, so the first bit generated ends in bit 7. After 8 bits the collector contents transfer to the output register.
REQ-011 The transfer SHALL occur when the output register is empty or is being read in the same cycle. Otherwise the cipher and collector SHALL stall, holding state, until the output register frees.
REQ-012 `keystream_valid` SHALL rise the cycle after a transfer. With no stall, the first rise is 1 + 1152 + 8 cycles after reset deassertion.
REQ-013 `keystream_byte` SHALL stay stable while `keystream_valid`=1.
REQ-014 The byte is consumed at a rising edge where `keystream_read`=1 and `keystream_valid`=1. `keystream_read` while `keystream_valid`=0 SHALL be ignored.
REQ-015 Simultaneous read and transfer in one cycle: the new byte replaces the old one and `keystream_valid` stays 1, giving a sustained throughput of 1 byte per 8 cycles.
REQ-016 No byte SHALL ever be dropped or duplicated.

Reset
REQ-017 While `rst_n`=1 the block SHALL:
- go to LOAD;
- clear the counter, the collector and its bit count;
- set `keystream_byte`=8'h00 and `keystream_valid`=0.
REQ-018 Reset asserted mid-INIT or mid-GEN SHALL abort the operation and discard any pending byte. The full 1152-step initialisation SHALL restart after release.

Structure
REQ-019 Package `trivium_pkg` SHALL hold:
- INIT_ROUNDS=1152, STATE_W=288, KEY_W=IV_W=80;
- the default KEY and IV constants;
- the FSM state enum.
REQ-020 The REQ-008 combinational update, taking state and returning next state and z, SHALL be a sub-module `trivium_core`. The FSM, collector and handshake SHALL live in the top level.

Verification
REQ-021 Reset release with no reads: `keystream_valid`=0 for 1160 cycles, then 1 at cycle 1161; `keystream_byte` then holds constant indefinitely, since the cipher is stalled.
REQ-022 Continuous `keystream_read`=1 after the first valid: a new byte every 8 cycles. Each of the first 64 bytes SHALL match a bit-accurate software model of REQ-007/REQ-008 with the zero key and zero IV.
REQ-023 Stall scenario: withhold read for 100 cycles after valid, then read continuously. The byte sequence SHALL equal the REQ-022 sequence with no gaps or repeats.
REQ-024 `keystream_read`=1 throughout INIT: no effect. The first byte SHALL equal byte 0 of the REQ-022 sequence.
REQ-025 Assert reset during GEN after 5 bytes: `keystream_valid`=0 next cycle. After release, byte 0 reappears at cycle 1161 with the same value as before.
